vend_controller: RTL and testbench
==================================

# vend_controller

Sequencing controller for the vending machine datapath. It owns the 8-bit credit register: it accumulates inserted coins, checks a product selection against a parameterised price table and hands the item to the dispense mechanism. It then pays out change one coin at a time over a valid/ready handshake. It sits between the coin acceptor and keypad front-end and the dispense/change actuators.

## Interface
Parameters:
- PRICE0, 8'd35, price of item 0 (cents, multiple of 5)
- PRICE1, 8'd50, price of item 1
- PRICE2, 8'd75, price of item 2
- PRICE3, 8'd100, price of item 3
- MAX_CREDIT, 8'd250, highest credit accepted (multiple of 5, ≤ 255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- coin_valid  in  1  one coin presented this cycle
- coin_code  in  2  00=5, 01=10, 10=25, 11=50 cents
- sel_valid  in  1  selection strobe
- sel_item  in  2  item index 0..3
- cancel  in  1  refund request
- dispense_ready  in  1  mechanism accepts item
- change_ready  in  1  change hopper accepts coin
- credit  out  8  current credit register
- dispense_valid  out  1  item request pending
- dispense_item  out  2  item being dispensed
- change_valid  out  1  change coin pending
- change_code  out  2  coin to return, same encoding as coin_code
- coin_reject  out  1  one-cycle pulse: presented coin not accepted
- sel_denied  out  1  one-cycle pulse: selection refused
- busy  out  1  high in VEND or CHANGE

## Operation
- States: COLLECT, VEND, CHANGE. Reset enters COLLECT.
- COLLECT priority per cycle: cancel > sel_valid > coin_valid.
  - cancel with credit>0 → CHANGE. With credit=0 → no-op.
  - sel_valid, credit ≥ PRICE[sel_item] → credit -= price, latch dispense_item, → VEND.
  - sel_valid, credit < price → sel_denied pulse, credit unchanged.
  - coin_valid with no higher-priority event and credit+value ≤ MAX_CREDIT → credit += value.
  - Any coin_valid not added to credit → coin_reject pulse. This covers overflow and coins pre-empted by cancel or selection.
- VEND: dispense_valid=1, dispense_item stable.
  - Handshake completes on dispense_valid & dispense_ready.
  - After handshake: credit>0 → CHANGE, else → COLLECT.
- CHANGE: change_valid=1. change_code is the largest coin ≤ credit, chosen from 50, 25, 10, 5.
  - On change_valid & change_ready: credit -= coin value.
  - When credit reaches 0 → COLLECT.
- In VEND/CHANGE: coin_valid → coin_reject pulse. sel_valid and cancel are ignored (no pulse).
- Credit is always a multiple of 5, so change always completes exactly to 0.
- Arithmetic is 9-bit internally for the overflow compare. The credit register never wraps.

## Timing
- All outputs are registered.
- Reset values:
  - state=COLLECT, credit=0
  - dispense_valid, change_valid, coin_reject, sel_denied, busy = 0
  - dispense_item=0, change_code=0
- Coin accepted at edge N: credit shows the new value from edge N (visible cycle N+1). There is no back-to-back restriction; one coin per cycle is allowed.
- Selection accepted at edge N: dispense_valid=1 and busy=1 from edge N. credit shows the decremented value at the same edge.
- dispense_valid holds until the handshake edge. It drops at that edge; change_valid rises at that edge if change is due.
- change_valid may stay high across consecutive coins. change_code and credit update at each handshake edge. change_valid drops at the edge where credit becomes 0.
- coin_reject and sel_denied are high for exactly one cycle per event.
- Asserting reset mid-VEND or mid-CHANGE aborts immediately: credit is lost and outputs go to their reset values asynchronously.

## Test plan
- Reset, then coins 25, 10 → credit 25 then 35. Select item 0 → dispense_valid, item=0, credit 0. dispense_ready → COLLECT, no change_valid.
- Coins 50, 50 (credit 100), select item 2 → credit 25, VEND. Handshake → CHANGE, change_code=10 (25). Handshake → credit 0, COLLECT.
- Credit 40, select item 1 (50) → sel_denied 1 cycle, credit stays 40. Cancel → change coins 25, 10, 5 in order, change_ready held high → 3 consecutive handshakes, then COLLECT.
- Credit 230, insert 50 → coin_reject pulse, credit 230. Insert 10 → 240.
- Same-cycle coin 25 + sel item 0 at credit 35 → selection wins, coin_reject pulse, credit 0. Coin during VEND → coin_reject, credit unchanged.
- Reset asserted while change_valid=1 with credit 15 → credit 0, change_valid 0, state COLLECT before the next clock edge.

Source files
------------

// File: rtl/vend_controller_if.sv
// rtl/vend_controller_if.sv - front-end and actuator signal bundle for the vending sequencer
interface vend_controller_if;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       dispense_ready;
    logic       change_ready;
    logic [7:0] credit;
    logic       dispense_valid;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [1:0] change_code;
    logic       coin_reject;
    logic       sel_denied;
    logic       busy;

    modport master (
        output coin_valid, coin_code, sel_valid, sel_item, cancel,
               dispense_ready, change_ready,
        input  credit, dispense_valid, dispense_item, change_valid,
               change_code, coin_reject, sel_denied, busy
    );

    modport slave (
        input  coin_valid, coin_code, sel_valid, sel_item, cancel,
               dispense_ready, change_ready,
        output credit, dispense_valid, dispense_item, change_valid,
               change_code, coin_reject, sel_denied, busy
    );
endinterface

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - credit accumulation, item dispense and coin-by-coin change sequencer
module vend_controller #(
    parameter logic [7:0] PRICE0     = 8'd35,
    parameter logic [7:0] PRICE1     = 8'd50,
    parameter logic [7:0] PRICE2     = 8'd75,
    parameter logic [7:0] PRICE3     = 8'd100,
    parameter logic [7:0] MAX_CREDIT = 8'd250
) (
    input  logic             clk,
    input  logic             reset,
    vend_controller_if.slave bus
);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_VEND    = 2'd1;
    localparam logic [1:0] ST_CHANGE  = 2'd2;

    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   coin_value = 8'd5;
            2'b01:   coin_value = 8'd10;
            2'b10:   coin_value = 8'd25;
            default: coin_value = 8'd50;
        endcase
    endfunction

    // Greedy choice; credit is always a multiple of 5 so this ends exactly at zero.
    function automatic logic [1:0] largest_coin(input logic [7:0] amount);
        if (amount >= 8'd50)      largest_coin = 2'b11;
        else if (amount >= 8'd25) largest_coin = 2'b10;
        else if (amount >= 8'd10) largest_coin = 2'b01;
        else                      largest_coin = 2'b00;
    endfunction

    function automatic logic [7:0] price_of(input logic [1:0] item);
        case (item)
            2'd0:    price_of = PRICE0;
            2'd1:    price_of = PRICE1;
            2'd2:    price_of = PRICE2;
            default: price_of = PRICE3;
        endcase
    endfunction

    logic [1:0] state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [1:0] item_q, item_d;
    logic       dval_q, dval_d;
    logic       cval_q, cval_d;
    logic [1:0] ccode_q, ccode_d;
    logic       reject_q, reject_d;
    logic       denied_q, denied_d;
    logic       busy_q, busy_d;

    logic [8:0] coin_sum;
    logic [7:0] sel_price;
    logic [7:0] credit_after_coin;

    assign coin_sum          = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_code)};
    assign sel_price         = price_of(bus.sel_item);
    assign credit_after_coin = credit_q - coin_value(ccode_q);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        item_d   = item_q;
        dval_d   = dval_q;
        cval_d   = cval_q;
        ccode_d  = ccode_q;
        reject_d = 1'b0;
        denied_d = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                // A cancel or selection pre-empts any coin presented alongside it.
                if (bus.cancel) begin
                    reject_d = bus.coin_valid;
                    if (credit_q != 8'd0) begin
                        state_d = ST_CHANGE;
                        cval_d  = 1'b1;
                        ccode_d = largest_coin(credit_q);
                    end
                end else if (bus.sel_valid) begin
                    reject_d = bus.coin_valid;
                    if (credit_q >= sel_price) begin
                        credit_d = credit_q - sel_price;
                        item_d   = bus.sel_item;
                        dval_d   = 1'b1;
                        state_d  = ST_VEND;
                    end else begin
                        denied_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (coin_sum <= {1'b0, MAX_CREDIT}) credit_d = coin_sum[7:0];
                    else                                reject_d = 1'b1;
                end
            end
            ST_VEND: begin
                reject_d = bus.coin_valid;
                if (bus.dispense_ready) begin
                    dval_d = 1'b0;
                    if (credit_q != 8'd0) begin
                        state_d = ST_CHANGE;
                        cval_d  = 1'b1;
                        ccode_d = largest_coin(credit_q);
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_CHANGE: begin
                reject_d = bus.coin_valid;
                if (bus.change_ready) begin
                    credit_d = credit_after_coin;
                    if (credit_after_coin == 8'd0) begin
                        cval_d  = 1'b0;
                        state_d = ST_COLLECT;
                    end else begin
                        ccode_d = largest_coin(credit_after_coin);
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
                dval_d  = 1'b0;
                cval_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_COLLECT;
            credit_q <= 8'd0;
            item_q   <= 2'd0;
            dval_q   <= 1'b0;
            cval_q   <= 1'b0;
            ccode_q  <= 2'd0;
            reject_q <= 1'b0;
            denied_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            dval_q   <= dval_d;
            cval_q   <= cval_d;
            ccode_q  <= ccode_d;
            reject_q <= reject_d;
            denied_q <= denied_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.credit         = credit_q;
    assign bus.dispense_valid = dval_q;
    assign bus.dispense_item  = item_q;
    assign bus.change_valid   = cval_q;
    assign bus.change_code    = ccode_q;
    assign bus.coin_reject    = reject_q;
    assign bus.sel_denied     = denied_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - scoreboard bench for vend_controller against a behavioural vending model
module tb_vend_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    vend_controller_if vif();

    vend_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int target;
        int credit;
        bit busy;
        bit dval;
        bit cval;
        bit rej;
        bit den;
        int item;
    } rec_t;

    rec_t recq[$];
    int   exp_disp[$];
    int   exp_chg[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int prices[4]    = '{35, 50, 75, 100};
    int coin_vals[4] = '{5, 10, 25, 50};

    int m_credit = 0;
    int m_mode = 0;      // 0 collecting, 1 dispensing, 2 paying change
    int m_item = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick_coin(input int amount);
        for (int k = 3; k >= 0; k--)
            if (coin_vals[k] <= amount) return k;
        return 0;
    endfunction

    // Predicts the effect of the coming clock edge from the inputs about to be applied.
    task automatic model_step(input bit cv, input int cc, input bit sv, input int si,
                              input bit can, input bit dr, input bit chr);
        rec_t r;
        r.target = cyc + 1;
        r.rej = 0;
        r.den = 0;
        if (m_mode == 0) begin
            if (can) begin
                r.rej = cv;
                if (m_credit > 0) m_mode = 2;
            end else if (sv) begin
                r.rej = cv;
                if (m_credit >= prices[si]) begin
                    m_credit -= prices[si];
                    m_item = si;
                    m_mode = 1;
                end else begin
                    r.den = 1;
                end
            end else if (cv) begin
                if (m_credit + coin_vals[cc] <= 250) m_credit += coin_vals[cc];
                else r.rej = 1;
            end
        end else if (m_mode == 1) begin
            r.rej = cv;
            if (dr) begin
                exp_disp.push_back(m_item);
                m_mode = (m_credit > 0) ? 2 : 0;
            end
        end else begin
            r.rej = cv;
            if (chr) begin
                int k;
                k = pick_coin(m_credit);
                exp_chg.push_back(k);
                m_credit -= coin_vals[k];
                if (m_credit == 0) m_mode = 0;
            end
        end
        r.credit = m_credit;
        r.busy = (m_mode != 0);
        r.dval = (m_mode == 1);
        r.cval = (m_mode == 2);
        r.item = m_item;
        recq.push_back(r);
    endtask

    task automatic step(input bit cv, input int cc, input bit sv, input int si,
                        input bit can, input bit dr, input bit chr);
        vif.coin_valid     = cv;
        vif.coin_code      = 2'(cc);
        vif.sel_valid      = sv;
        vif.sel_item       = 2'(si);
        vif.cancel         = can;
        vif.dispense_ready = dr;
        vif.change_ready   = chr;
        model_step(cv, cc, sv, si, can, dr, chr);
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int cc);
        step(1, cc, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input bit dr, input bit chr);
        step(0, 0, 0, 0, 0, dr, chr);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            while (recq.size() > 0 && recq[0].target <= cyc) begin
                rec_t r;
                r = recq.pop_front();
                check("credit", int'(vif.credit), r.credit);
                check("busy", int'(vif.busy), int'(r.busy));
                check("dispense_valid", int'(vif.dispense_valid), int'(r.dval));
                check("change_valid", int'(vif.change_valid), int'(r.cval));
                check("coin_reject", int'(vif.coin_reject), int'(r.rej));
                check("sel_denied", int'(vif.sel_denied), int'(r.den));
                if (r.dval) check("dispense_item", int'(vif.dispense_item), r.item);
            end
            if (vif.dispense_valid && vif.dispense_ready) begin
                if (exp_disp.size() == 0) check("dispense_unexpected", 1, 0);
                else check("dispense_handshake_item", int'(vif.dispense_item), exp_disp.pop_front());
            end
            if (vif.change_valid && vif.change_ready) begin
                if (exp_chg.size() == 0) check("change_unexpected", 1, 0);
                else check("change_handshake_code", int'(vif.change_code), exp_chg.pop_front());
            end
        end
    end

    initial begin
        vif.coin_valid = 0; vif.coin_code = 0; vif.sel_valid = 0; vif.sel_item = 0;
        vif.cancel = 0; vif.dispense_ready = 0; vif.change_ready = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_credit", int'(vif.credit), 0);
        check("rst_dispense_valid", int'(vif.dispense_valid), 0);
        check("rst_change_valid", int'(vif.change_valid), 0);
        check("rst_busy", int'(vif.busy), 0);
        check("rst_coin_reject", int'(vif.coin_reject), 0);
        check("rst_sel_denied", int'(vif.sel_denied), 0);
        check("rst_dispense_item", int'(vif.dispense_item), 0);
        check("rst_change_code", int'(vif.change_code), 0);
        reset = 0;

        // exact purchase, no change
        coin(2); coin(1);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(0, 0);
        idle(1, 0);
        idle(0, 0);

        // purchase with 25 change
        coin(3); coin(3);
        step(0, 0, 1, 2, 0, 0, 0);
        idle(1, 0);
        idle(0, 1);
        idle(0, 0);

        // denied selection then refund of 40
        coin(2); coin(1); coin(0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        repeat (3) idle(0, 1);
        idle(0, 0);

        // overflow guard near MAX_CREDIT
        repeat (4) coin(3);
        coin(2); coin(0);
        coin(3);
        coin(1);
        step(0, 0, 0, 0, 1, 0, 0);
        repeat (10) idle(1, 1);

        // selection wins over same-cycle coin; coin during dispense
        coin(2); coin(1);
        step(1, 2, 1, 0, 0, 0, 0);
        step(1, 3, 0, 0, 0, 0, 0);
        idle(1, 0);
        idle(0, 0);

        // reset while paying out 15
        coin(1); coin(0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(0, 0);
        check("pre_reset_change_valid", int'(vif.change_valid), 1);
        check("pre_reset_credit", int'(vif.credit), 15);
        #2;
        reset = 1;
        #1;
        check("async_rst_credit", int'(vif.credit), 0);
        check("async_rst_change_valid", int'(vif.change_valid), 0);
        check("async_rst_busy", int'(vif.busy), 0);
        recq.delete();
        exp_disp.delete();
        exp_chg.delete();
        m_credit = 0;
        m_mode = 0;
        m_item = 0;
        @(posedge clk);
        #1;
        reset = 0;

        for (int i = 0; i < 1500; i++) begin
            bit cv, sv, can, dr, chr;
            cv  = ($urandom_range(0, 99) < 45);
            sv  = ($urandom_range(0, 99) < 12);
            can = ($urandom_range(0, 99) < 4);
            dr  = ($urandom_range(0, 99) < 50);
            chr = ($urandom_range(0, 99) < 60);
            step(cv, $urandom_range(0, 3), sv, $urandom_range(0, 3), can, dr, chr);
        end

        repeat (15) idle(1, 1);
        idle(0, 0);
        @(negedge clk);
        @(negedge clk);
        check("drain_records", recq.size(), 0);
        check("drain_dispense", exp_disp.size(), 0);
        check("drain_change", exp_chg.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
